alu_issue: RTL and testbench

ALU_ISSUE -- requirements
Module: alu_issue

---
 rtl/alu_issue_pkg.sv | 72 +++++++
 rtl/alu_issue_op2_shifter.sv | 48 ++++
 rtl/alu_issue.sv | 134 +++++++++++++
 tb/tb_alu_issue.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | alu_issue_pkg : opcodes, FSM states, shift codes, decode helpers |
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
package alu_issue_pkg;

  localparam int unsigned ALU_LAT_MIN = 1;
  localparam int unsigned ALU_LAT_MAX = 7;

  localparam logic [3:0] OP_AND = 4'h0;
  localparam logic [3:0] OP_EOR = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_RSB = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_ADC = 4'h5;
  localparam logic [3:0] OP_SBC = 4'h6;
  localparam logic [3:0] OP_RSC = 4'h7;
  localparam logic [3:0] OP_TST = 4'h8;
  localparam logic [3:0] OP_TEQ = 4'h9;
  localparam logic [3:0] OP_CMP = 4'hA;
  localparam logic [3:0] OP_CMN = 4'hB;
  localparam logic [3:0] OP_ORR = 4'hC;
  localparam logic [3:0] OP_MOV = 4'hD;
  localparam logic [3:0] OP_BIC = 4'hE;
  localparam logic [3:0] OP_MVN = 4'hF;

  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_ISSUE = 2'd2,
    ST_WB    = 2'd3
  } state_e;

  // Data-processing fields kept after acceptance; S bit is deliberately dropped.
  typedef struct packed {
    logic [3:0]  cond;
    logic        imm;
    logic [3:0]  opcode;
    logic [3:0]  rn;
    logic [3:0]  rd;
    logic [11:0] op2;
  } dp_instr_t;

  function automatic dp_instr_t decode(input logic [31:0] w);
    dp_instr_t d;
    d.cond   = w[31:28];
    d.imm    = w[25];
    d.opcode = w[24:21];
    d.rn     = w[19:16];
    d.rd     = w[15:12];
    d.op2    = w[11:0];
    return d;
  endfunction

  function automatic logic is_supported(input logic [31:0] w);
    logic carry_op;
    carry_op = (w[24:21] == OP_ADC) || (w[24:21] == OP_SBC) || (w[24:21] == OP_RSC);
    return (w[27:26] == 2'b00) && !carry_op && !(!w[25] && w[4]);
  endfunction

  function automatic logic writes_rd(input logic [3:0] op);
    return !((op == OP_TST) || (op == OP_TEQ) || (op == OP_CMP) || (op == OP_CMN));
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_issue_op2_shifter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | op2_shifter : combinational ARM operand2 (rotated imm / shifted) |
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
module op2_shifter
  import alu_issue_pkg::*;
(
  input  logic        imm_i,
  input  logic [11:0] field_i,
  input  logic [31:0] rf_db_i,
  output logic [31:0] op2_o
);

  logic [4:0]  w_rot_amt;
  logic [63:0] w_imm_dbl;
  logic [31:0] w_imm_val;
  logic [4:0]  w_sh_amt;
  logic [1:0]  w_sh_type;
  logic [63:0] w_reg_dbl;
  logic [31:0] w_reg_val;

  // Rotations are done as a right shift of the value concatenated with itself.
  assign w_rot_amt = {field_i[11:8], 1'b0};
  assign w_imm_dbl = {2{24'd0, field_i[7:0]}};
  assign w_imm_val = 32'(w_imm_dbl >> w_rot_amt);

  assign w_sh_amt  = field_i[11:7];
  assign w_sh_type = field_i[6:5];
  assign w_reg_dbl = {rf_db_i, rf_db_i};

  // A zero amount encodes #32 for LSR/ASR; ROR #0 stays a plain pass-through.
  always_comb begin
    w_reg_val = rf_db_i;
    case (w_sh_type)
      SH_LSL: w_reg_val = rf_db_i << w_sh_amt;
      SH_LSR: w_reg_val = (w_sh_amt == 5'd0) ? 32'd0 : (rf_db_i >> w_sh_amt);
      SH_ASR: w_reg_val = (w_sh_amt == 5'd0) ? {32{rf_db_i[31]}}
                                             : 32'($signed(rf_db_i) >>> w_sh_amt);
      SH_ROR: w_reg_val = 32'(w_reg_dbl >> w_sh_amt);
      default: w_reg_val = rf_db_i;
    endcase
  end

  assign op2_o = imm_i ? w_imm_val : w_reg_val;

endmodule
`default_nettype wire

// File: rtl/alu_issue.sv
`default_nettype none
// +------------------------------------------------------------------+
// | alu_issue : fetches operands, issues one ARM data-processing op  |
// | to an external ALU and writes the result back. Revision 1.0      |
// +------------------------------------------------------------------+
module alu_issue
  import alu_issue_pkg::*;
#(
  parameter int unsigned ALU_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  output logic        instr_ready,
  output logic [3:0]  rf_ra,
  output logic [3:0]  rf_rb,
  input  logic [31:0] rf_da,
  input  logic [31:0] rf_db,
  output logic [3:0]  alu_cond,
  output logic [4:0]  alu_operation,
  output logic [31:0] alu_data1,
  output logic [31:0] alu_data2,
  input  logic [31:0] alu_result,
  input  logic        alu_execute,
  output logic        wb_en,
  output logic [3:0]  wb_addr,
  output logic [31:0] wb_data,
  output logic        busy,
  output logic        unsupported
);

  localparam logic [2:0] LAT_LAST = 3'(ALU_LAT - 1);

  if ((ALU_LAT < ALU_LAT_MIN) || (ALU_LAT > ALU_LAT_MAX)) begin : g_lat_range_err
    $error("alu_issue: ALU_LAT out of range");
  end

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  dp_instr_t   instr_q;
  logic [3:0]  cond_q;
  logic [4:0]  oper_q;
  logic [31:0] data1_q, data2_q;
  logic        unsup_q;

  logic        w_accept;
  logic        w_supported;
  logic [31:0] w_op2;
  logic        w_unused_sbit;

  assign w_unused_sbit = instr[20];
  assign w_accept      = instr_valid && (state_q == ST_IDLE);
  assign w_supported   = is_supported(instr);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (w_accept && w_supported) state_d = ST_READ;
      end
      ST_READ: begin
        state_d = ST_ISSUE;
        cnt_d   = 3'd0;
      end
      ST_ISSUE: begin
        if (cnt_q == LAT_LAST) begin
          state_d = ST_WB;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      ST_WB: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
      instr_q <= '0;
      cond_q  <= 4'd0;
      oper_q  <= 5'd0;
      data1_q <= 32'd0;
      data2_q <= 32'd0;
      unsup_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      unsup_q <= w_accept && !w_supported;
      if (w_accept) instr_q <= decode(instr);
      // Register data arrives in READ, one cycle after the addresses went out.
      if (state_q == ST_READ) begin
        cond_q  <= instr_q.cond;
        oper_q  <= {1'b0, instr_q.opcode};
        data1_q <= rf_da;
        data2_q <= w_op2;
      end
    end
  end

  op2_shifter u_op2_shifter (
    .imm_i   (instr_q.imm),
    .field_i (instr_q.op2),
    .rf_db_i (rf_db),
    .op2_o   (w_op2)
  );

  // Addresses follow the live word while idle so the read overlaps acceptance.
  assign rf_ra = (state_q == ST_IDLE) ? instr[19:16] : instr_q.rn;
  assign rf_rb = (state_q == ST_IDLE) ? instr[3:0]   : instr_q.op2[3:0];

  assign instr_ready   = (state_q == ST_IDLE);
  assign busy          = (state_q != ST_IDLE);
  assign unsupported   = unsup_q;
  assign alu_cond      = cond_q;
  assign alu_operation = oper_q;
  assign alu_data1     = data1_q;
  assign alu_data2     = data2_q;

  assign wb_en   = (state_q == ST_WB) && alu_execute && writes_rd(instr_q.opcode);
  assign wb_addr = (state_q == ST_WB) ? instr_q.rd : 4'd0;
  assign wb_data = (state_q == ST_WB) ? alu_result : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue.sv
`default_nettype none
// Scoreboard bench for alu_issue: one DUT at ALU_LAT=1, one at ALU_LAT=3 for throughput.
module tb_alu_issue;

  localparam int LAT1 = 1;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  always #5 clk = ~clk;

  logic        instr_valid = 1'b0;
  logic [31:0] instr = 32'd0;
  logic        instr_ready;
  logic [3:0]  rf_ra, rf_rb;
  logic [31:0] rf_da = 32'd0, rf_db = 32'd0;
  logic [3:0]  alu_cond;
  logic [4:0]  alu_operation;
  logic [31:0] alu_data1, alu_data2, alu_result;
  logic        alu_execute = 1'b0;
  logic        wb_en;
  logic [3:0]  wb_addr;
  logic [31:0] wb_data;
  logic        busy, unsupported;

  logic        instr_valid3 = 1'b0;
  logic [31:0] instr3 = 32'd0;
  logic        instr_ready3;
  logic [3:0]  rf_ra3, rf_rb3;
  logic [31:0] rf_da3 = 32'd0, rf_db3 = 32'd0;
  logic [3:0]  alu_cond3;
  logic [4:0]  alu_operation3;
  logic [31:0] alu_data13, alu_data23, alu_result3;
  logic        alu_execute3 = 1'b1;
  logic        wb_en3;
  logic [3:0]  wb_addr3;
  logic [31:0] wb_data3;
  logic        busy3, unsupported3;

  logic [31:0] regs [16];

  always @(posedge clk) begin
    rf_da  <= regs[rf_ra];
    rf_db  <= regs[rf_rb];
    rf_da3 <= regs[rf_ra3];
    rf_db3 <= regs[rf_rb3];
  end

  assign alu_result  = alu_data1 + alu_data2;
  assign alu_result3 = alu_data13 + alu_data23;

  alu_issue #(.ALU_LAT(LAT1)) u_dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .rf_ra(rf_ra), .rf_rb(rf_rb), .rf_da(rf_da), .rf_db(rf_db),
    .alu_cond(alu_cond), .alu_operation(alu_operation), .alu_data1(alu_data1),
    .alu_data2(alu_data2), .alu_result(alu_result), .alu_execute(alu_execute),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .busy(busy),
    .unsupported(unsupported)
  );

  alu_issue #(.ALU_LAT(3)) u_dut3 (
    .clk(clk), .reset(reset), .instr_valid(instr_valid3), .instr(instr3),
    .instr_ready(instr_ready3), .rf_ra(rf_ra3), .rf_rb(rf_rb3), .rf_da(rf_da3), .rf_db(rf_db3),
    .alu_cond(alu_cond3), .alu_operation(alu_operation3), .alu_data1(alu_data13),
    .alu_data2(alu_data23), .alu_result(alu_result3), .alu_execute(alu_execute3),
    .wb_en(wb_en3), .wb_addr(wb_addr3), .wb_data(wb_data3), .busy(busy3),
    .unsupported(unsupported3)
  );

  typedef struct {
    logic [3:0]  cond;
    logic [4:0]  op;
    logic [31:0] d1;
    logic [31:0] d2;
    logic        wb;
    logic [3:0]  rd;
  } exp_t;

  exp_t        sb [$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] last_d2 = 32'd0;
  logic [4:0]  last_op = 5'd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [3:0] cond, input logic i, input logic [3:0] op,
                                     input logic s, input logic [3:0] rn, input logic [3:0] rd,
                                     input logic [11:0] f);
    return {cond, 2'b00, i, op, s, rn, rd, f};
  endfunction

  function automatic logic [31:0] ror_bits(input logic [31:0] v, input int n);
    logic [31:0] r;
    r = v;
    for (int k = 0; k < n; k++) r = {r[0], r[31:1]};
    return r;
  endfunction

  function automatic logic [31:0] model_op2(input logic [31:0] w);
    logic [31:0] v;
    int          n;
    if (w[25]) return ror_bits({24'd0, w[7:0]}, 2 * int'(w[11:8]));
    v = regs[w[3:0]];
    n = int'(w[11:7]);
    case (w[6:5])
      2'b00: return v << n;
      2'b01: return (n == 0) ? 32'd0 : (v >> n);
      2'b10: begin
        if (n == 0) n = 32;
        for (int k = 0; k < n; k++) v = {v[31], v[31:1]};
        return v;
      end
      default: return ror_bits(v, n);
    endcase
  endfunction

  task automatic send(input string name, input logic [31:0] w, input logic ex);
    exp_t e;
    exp_t g;
    check({name, "_ready"}, instr_ready, 1);
    instr = w; instr_valid = 1'b1; alu_execute = ex;
    #1;
    check({name, "_rf_ra"}, rf_ra, w[19:16]);
    check({name, "_rf_rb"}, rf_rb, w[3:0]);
    e.cond = w[31:28];
    e.op   = {1'b0, w[24:21]};
    e.d1   = regs[w[19:16]];
    e.d2   = model_op2(w);
    e.wb   = ex && !((w[24:21] >= 4'h8) && (w[24:21] <= 4'hB));
    e.rd   = w[15:12];
    sb.push_back(e);
    @(posedge clk); #1;
    instr_valid = 1'b0;
    check({name, "_busy"}, busy, 1);
    for (int k = 0; k < 1 + LAT1; k++) begin
      check({name, "_wb_early"}, wb_en, 0);
      @(posedge clk); #1;
    end
    g = sb.pop_front();
    check({name, "_cond"}, alu_cond, g.cond);
    check({name, "_op"}, alu_operation, g.op);
    check({name, "_d1"}, alu_data1, g.d1);
    check({name, "_d2"}, alu_data2, g.d2);
    check({name, "_wb_en"}, wb_en, g.wb);
    if (g.wb) begin
      check({name, "_wb_addr"}, wb_addr, g.rd);
      check({name, "_wb_data"}, wb_data, g.d1 + g.d2);
    end
    last_d2 = g.d2;
    last_op = g.op;
    @(posedge clk); #1;
    check({name, "_idle"}, instr_ready, 1);
    check({name, "_wb_after"}, wb_en, 0);
  endtask

  task automatic reject(input string name, input logic [31:0] w);
    instr = w; instr_valid = 1'b1; alu_execute = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    check({name, "_unsup"}, unsupported, 1);
    check({name, "_ready"}, instr_ready, 1);
    check({name, "_busy"}, busy, 0);
    check({name, "_d2_hold"}, alu_data2, last_d2);
    check({name, "_op_hold"}, alu_operation, last_op);
    check({name, "_wb"}, wb_en, 0);
    @(posedge clk); #1;
    check({name, "_unsup_clr"}, unsupported, 0);
    check({name, "_ready2"}, instr_ready, 1);
  endtask

  initial begin
    logic [31:0] wa, wb;
    int          acc;
    for (int r = 0; r < 16; r++) regs[r] = 32'h0101_0101 * r;
    regs[0] = 32'd0;
    regs[1] = 32'd5;
    regs[2] = 32'h8000_0000;
    regs[3] = 32'h0000_00F3;
    regs[4] = 32'h1234_5678;

    #12;
    check("rst_busy", busy, 0);
    check("rst_d1", alu_data1, 0);
    check("rst_d2", alu_data2, 0);
    check("rst_op", alu_operation, 0);
    check("rst_cond", alu_cond, 0);
    check("rst_wb_en", wb_en, 0);
    check("rst_unsup", unsupported, 0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    check("rst_ready", instr_ready, 1);

    send("add_imm", 32'hE28124FF, 1'b1);
    check("add_imm_d2_lit", alu_data2, 32'hFF00_0000);
    send("sub_asr0", 32'hE0413042, 1'b1);
    check("sub_asr0_lit", alu_data2, 32'hFFFF_FFFF);
    send("sub_lsr0", 32'hE0413022, 1'b1);
    check("sub_lsr0_lit", alu_data2, 32'd0);
    send("add_lsl4", mk(4'hE, 1'b0, 4'h4, 1'b0, 4'd4, 4'd5, {5'd4, 2'b00, 1'b0, 4'd3}), 1'b1);
    send("eor_ror8", mk(4'hE, 1'b0, 4'h1, 1'b1, 4'd1, 4'd6, {5'd8, 2'b11, 1'b0, 4'd4}), 1'b1);
    send("mov_ror0", mk(4'hE, 1'b0, 4'hD, 1'b0, 4'd0, 4'd8, {5'd0, 2'b11, 1'b0, 4'd4}), 1'b1);
    send("cmp_imm", mk(4'hE, 1'b1, 4'hA, 1'b1, 4'd1, 4'd1, 12'h003), 1'b1);
    check("cmp_op_lit", alu_operation, 5'b01010);
    send("moveq_nx", mk(4'h0, 1'b1, 4'hD, 1'b0, 4'd0, 4'd4, 12'h007), 1'b0);
    send("mov_pc", mk(4'hE, 1'b0, 4'hD, 1'b0, 4'd0, 4'd15, {5'd1, 2'b01, 1'b0, 4'd3}), 1'b1);
    send("orr_rot0", mk(4'hE, 1'b1, 4'hC, 1'b0, 4'd1, 4'd7, 12'h055), 1'b1);

    reject("rej_adc", mk(4'hE, 1'b1, 4'h5, 1'b0, 4'd1, 4'd2, 12'h001));
    reject("rej_ldr", 32'hE591_2000);
    reject("rej_regsh", mk(4'hE, 1'b0, 4'h4, 1'b0, 4'd1, 4'd2, 12'h311));

    // Back-to-back on the ALU_LAT=3 instance.
    wa = mk(4'hE, 1'b1, 4'h4, 1'b0, 4'd1, 4'd2, 12'h0FF);
    wb = mk(4'hE, 1'b1, 4'hD, 1'b0, 4'd0, 4'd9, 12'h001);
    check("b2b_ready0", instr_ready3, 1);
    instr3 = wa; instr_valid3 = 1'b1;
    @(posedge clk); #1;
    instr3 = wb;
    acc = 0;
    for (int c = 1; (c <= 12) && (acc == 0); c++) begin
      if (c == 5) begin
        check("b2b_wbA_en", wb_en3, 1);
        check("b2b_wbA_addr", wb_addr3, 4'd2);
        check("b2b_wbA_data", wb_data3, regs[1] + 32'h0000_00FF);
      end
      if (instr_ready3) acc = c;
      else begin
        @(posedge clk); #1;
      end
    end
    check("b2b_interval", acc, 6);
    @(posedge clk); #1;
    instr_valid3 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("b2b_wbB_en", wb_en3, 1);
    check("b2b_wbB_addr", wb_addr3, 4'd9);
    check("b2b_wbB_data", wb_data3, regs[wb[19:16]] + model_op2(wb));

    // Reset in the middle of ISSUE.
    instr = 32'hE28124FF; instr_valid = 1'b1; alu_execute = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk); #1;
    check("mid_busy_pre", busy, 1);
    reset = 1'b0;
    #1;
    check("mid_busy", busy, 0);
    check("mid_ready", instr_ready, 1);
    check("mid_wb_en", wb_en, 0);
    check("mid_d1", alu_data1, 0);
    check("mid_d2", alu_data2, 0);
    check("mid_op", alu_operation, 0);
    check("mid_cond", alu_cond, 0);
    check("mid_wb_addr", wb_addr, 0);
    check("mid_wb_data", wb_data, 0);
    check("mid_unsup", unsupported, 0);
    @(posedge clk); @(posedge clk); #1;
    check("mid_no_wb", wb_en, 0);
    reset = 1'b1;
    last_d2 = 32'd0;
    last_op = 5'd0;
    @(posedge clk); #1;
    check("post_rst_ready", instr_ready, 1);
    send("post_rst", mk(4'hE, 1'b0, 4'h2, 1'b0, 4'd4, 4'd10, {5'd3, 2'b10, 1'b0, 4'd2}), 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
